axis_packet_injector: RTL and testbench

- Software-driven AXIS packet transmitter that feeds one ingress port of the packet switch.
- Host loads one packet word-by-word through the 8-bit Avalon-MM register slave, sets the destination egress index, then issues START.
- The block streams the buffered packet as a single AXIS packet (tdata/tvalid/tlast/tdest) under tready backpressure, then raises irq.
- Used by test firmware and loopback diagnostics to inject traffic into the switch fabric.

---
 rtl/packet_filter_pkg.sv | 31 +++
 rtl/injector_buffer.sv | 28 ++
 rtl/axis_packet_injector.sv | 184 ++++++++++++++++++
 tb/tb_axis_packet_injector.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_filter_pkg.sv
// Shared constants for the AXIS packet injector: register map, CTRL/STATUS bits, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package packet_filter_pkg;

  // Avalon-MM word addresses of the host-visible registers
  localparam logic [7:0] ADDR_CTRL    = 8'h00;  // write CTRL / read STATUS
  localparam logic [7:0] ADDR_DEST    = 8'h01;
  localparam logic [7:0] ADDR_DATA_LO = 8'h02;
  localparam logic [7:0] ADDR_DATA_HI = 8'h03;
  localparam logic [7:0] ADDR_COUNT   = 8'h04;
  localparam logic [7:0] ADDR_PKT_CNT = 8'h05;

  // CTRL write bits
  localparam int CTRL_START   = 0;
  localparam int CTRL_CLEAR   = 1;
  localparam int CTRL_IRQ_ACK = 2;

  // STATUS read bits
  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_ERR   = 2;
  localparam int ST_EMPTY = 3;
  localparam int ST_IRQ   = 4;

  typedef enum logic {
    INJ_IDLE = 1'b0,
    INJ_SEND = 1'b1
  } inj_state_t;

endpackage

// File: rtl/injector_buffer.sv
// Packet word store: DEPTH x DATA_WIDTH, synchronous write port, asynchronous read port.
// Latency: write lands on the clock edge; read data follows raddr combinationally.
// Backpressure: none; the owner guarantees writes only to valid slots.
module injector_buffer #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 16,
  parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Store one word per write strobe; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/axis_packet_injector.sv
// Host-loaded packet buffer streamed out as one AXIS packet on START, irq on completion.
// Latency: tvalid rises the cycle after the START write; one beat per cycle while tready=1.
// Backpressure: tready low stalls the beat in place; tdata/tlast/tdest held, tvalid stays high.
module axis_packet_injector
  import packet_filter_pkg::*;
#(
  parameter int N_PORTS    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = $clog2(N_PORTS),
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            writedata,
  input  logic                  write,
  input  logic                  chipselect,
  input  logic [7:0]            address,
  input  logic                  read,
  output logic [7:0]            readdata,
  output logic [DATA_WIDTH-1:0] tx_tdata,
  output logic                  tx_tvalid,
  output logic                  tx_tlast,
  output logic [IDX_WIDTH-1:0]  tx_tdest,
  input  logic                  tx_tready,
  output logic                  irq
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  inj_state_t            state_q, state_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [CNT_WIDTH-1:0]  rd_idx_q, rd_idx_d;
  logic [7:0]            staged_lo_q, staged_lo_d;
  logic [IDX_WIDTH-1:0]  dest_q, dest_d;
  logic [IDX_WIDTH-1:0]  tdest_q, tdest_d;
  logic                  err_q, err_d;
  logic                  irq_q, irq_d;
  logic [7:0]            pkt_cnt_q, pkt_cnt_d;
  logic [7:0]            readdata_q, readdata_d;

  logic                  buf_we;
  logic [DATA_WIDTH-1:0] buf_wdata;
  logic [DATA_WIDTH-1:0] buf_rdata;

  logic                  wr_en, rd_en;
  logic                  sending, last_beat, beat_done;
  logic                  full, empty;
  logic [7:0]            status;

  assign wr_en     = chipselect & write;
  assign rd_en     = chipselect & read;
  assign sending   = (state_q == INJ_SEND);
  assign last_beat = sending && (rd_idx_q == (count_q - CNT_WIDTH'(1)));
  assign beat_done = sending & tx_tready;
  assign full      = (count_q == CNT_WIDTH'(DEPTH));
  assign empty     = (count_q == '0);
  assign buf_wdata = {writedata, staged_lo_q};

  // STATUS view assembled from live state
  always_comb begin
    status           = 8'h00;
    status[ST_BUSY]  = sending;
    status[ST_FULL]  = full;
    status[ST_ERR]   = err_q;
    status[ST_EMPTY] = empty;
    status[ST_IRQ]   = irq_q;
  end

  injector_buffer #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (AW)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (count_q[AW-1:0]),
    .wdata (buf_wdata),
    .raddr (rd_idx_q[AW-1:0]),
    .rdata (buf_rdata)
  );

  // Register writes, FSM transitions and read-data mux; completion is applied last so it beats IRQ_ACK
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rd_idx_d    = rd_idx_q;
    staged_lo_d = staged_lo_q;
    dest_d      = dest_q;
    tdest_d     = tdest_q;
    err_d       = err_q;
    irq_d       = irq_q;
    pkt_cnt_d   = pkt_cnt_q;
    readdata_d  = readdata_q;
    buf_we      = 1'b0;

    if (wr_en) begin
      case (address)
        ADDR_CTRL: begin
          if (writedata[CTRL_IRQ_ACK]) irq_d = 1'b0;
          if (writedata[CTRL_CLEAR]) begin
            // CLEAR takes priority over START; an in-flight packet keeps its words
            err_d = 1'b0;
            if (!sending) count_d = '0;
          end else if (writedata[CTRL_START] && !sending && !empty) begin
            state_d  = INJ_SEND;
            tdest_d  = dest_q;
            rd_idx_d = '0;
          end
        end
        ADDR_DEST: dest_d = writedata[IDX_WIDTH-1:0];
        ADDR_DATA_LO: begin
          if (sending) err_d = 1'b1;
          else         staged_lo_d = writedata;
        end
        ADDR_DATA_HI: begin
          if (sending || full) begin
            err_d = 1'b1;
          end else begin
            buf_we  = 1'b1;
            count_d = count_q + CNT_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end

    if (beat_done) begin
      if (last_beat) begin
        state_d   = INJ_IDLE;
        count_d   = '0;
        pkt_cnt_d = pkt_cnt_q + 8'd1;
        irq_d     = 1'b1;
      end else begin
        rd_idx_d = rd_idx_q + CNT_WIDTH'(1);
      end
    end

    if (rd_en) begin
      case (address)
        ADDR_CTRL:    readdata_d = status;
        ADDR_DEST:    readdata_d = 8'(dest_q);
        ADDR_COUNT:   readdata_d = 8'(count_q);
        ADDR_PKT_CNT: readdata_d = pkt_cnt_q;
        default:      readdata_d = 8'h00;
      endcase
    end
  end

  // State register with asynchronous reset; buffer contents live in the sub-module
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= INJ_IDLE;
      count_q     <= '0;
      rd_idx_q    <= '0;
      staged_lo_q <= '0;
      dest_q      <= '0;
      tdest_q     <= '0;
      err_q       <= 1'b0;
      irq_q       <= 1'b0;
      pkt_cnt_q   <= '0;
      readdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_idx_q    <= rd_idx_d;
      staged_lo_q <= staged_lo_d;
      dest_q      <= dest_d;
      tdest_q     <= tdest_d;
      err_q       <= err_d;
      irq_q       <= irq_d;
      pkt_cnt_q   <= pkt_cnt_d;
      readdata_q  <= readdata_d;
    end
  end

  assign tx_tvalid = sending;
  assign tx_tlast  = last_beat;
  assign tx_tdata  = sending ? buf_rdata : '0;
  assign tx_tdest  = sending ? tdest_q : dest_q;
  assign irq       = irq_q;
  assign readdata  = readdata_q;

endmodule

// File: tb/tb_axis_packet_injector.sv
// Randomized scoreboard bench for axis_packet_injector against a queue-based packet model.
// Latency: expects tvalid one cycle after START and back-to-back beats while tready=1.
// Backpressure: drives tready all-ones, a fixed stall pattern, random, or held low.
module tb_axis_packet_injector;

  localparam int N_PORTS    = 4;
  localparam int DATA_WIDTH = 16;
  localparam int IDX_WIDTH  = 2;
  localparam int DEPTH      = 16;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [7:0]            writedata;
  logic                  write;
  logic                  chipselect;
  logic [7:0]            address;
  logic                  read;
  logic [7:0]            readdata;
  logic [DATA_WIDTH-1:0] tx_tdata;
  logic                  tx_tvalid;
  logic                  tx_tlast;
  logic [IDX_WIDTH-1:0]  tx_tdest;
  logic                  tx_tready;
  logic                  irq;

  always #5 clk = ~clk;

  axis_packet_injector #(
    .N_PORTS    (N_PORTS),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH),
    .DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .writedata  (writedata),
    .write      (write),
    .chipselect (chipselect),
    .address    (address),
    .read       (read),
    .readdata   (readdata),
    .tx_tdata   (tx_tdata),
    .tx_tvalid  (tx_tvalid),
    .tx_tlast   (tx_tlast),
    .tx_tdest   (tx_tdest),
    .tx_tready  (tx_tready),
    .irq        (irq)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic [1:0]  dest;
  } beat_t;

  beat_t       exp_q[$];
  logic [15:0] m_words[$];
  bit          m_err, m_irq, m_busy;
  int          m_pkt;
  logic [1:0]  m_dest;

  function automatic logic [7:0] model_status();
    logic [7:0] s;
    s    = 8'h00;
    s[0] = m_busy;
    s[1] = (m_words.size() == DEPTH);
    s[2] = m_err;
    s[3] = (m_words.size() == 0);
    s[4] = m_irq;
    return s;
  endfunction

  // ---------------- tready driver ----------------
  int ready_mode = 0;   // 0 always ready, 1 fixed pattern, 2 random, 3 held low
  int pat_idx    = 0;
  bit ready_pat[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    tx_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: tx_tready = 1'b1;
        1: begin tx_tready = ready_pat[pat_idx % 6]; pat_idx++; end
        2: tx_tready = 1'($urandom_range(0, 1));
        default: tx_tready = 1'b0;
      endcase
    end
  end

  // ---------------- AXIS monitor / scoreboard ----------------
  int    hs_count    = 0;
  int    valid_cycles = 0;
  bit    prev_stall  = 1'b0;
  beat_t prev_beat;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_tvalid_held", {31'd0, tx_tvalid}, 32'd1);
          check("stall_beat_held", {13'd0, tx_tdata, tx_tlast, tx_tdest}, {13'd0, prev_beat});
        end
        if (!tx_tvalid) check("idle_tdata_zero", {16'd0, tx_tdata}, 32'd0);
        if (tx_tvalid) valid_cycles++;
        if (tx_tvalid && tx_tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got data 0x%0h last %0d, expected no beat", tx_tdata, tx_tlast);
          end else begin
            beat_t e;
            e = exp_q.pop_front();
            check("beat", {13'd0, tx_tdata, tx_tlast, tx_tdest}, {13'd0, e});
          end
          hs_count++;
        end
        prev_stall = tx_tvalid && !tx_tready;
        prev_beat  = {tx_tdata, tx_tlast, tx_tdest};
      end
    end
  end

  // ---------------- Avalon-MM host tasks ----------------
  task automatic avl_wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic avl_rd(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(posedge clk);
    #1;
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic push_word(input logic [15:0] w);
    avl_wr(8'h02, w[7:0]);
    avl_wr(8'h03, w[15:8]);
    if (m_busy || m_words.size() == DEPTH) m_err = 1'b1;
    else m_words.push_back(w);
  endtask

  task automatic set_dest(input logic [1:0] d);
    avl_wr(8'h01, {6'd0, d});
    m_dest = d;
  endtask

  task automatic ctrl(input logic [7:0] v);
    avl_wr(8'h00, v);
    if (v[2]) m_irq = 1'b0;
    if (v[1]) begin
      m_err = 1'b0;
      if (!m_busy) m_words.delete();
    end else if (v[0] && !m_busy && m_words.size() > 0) begin
      foreach (m_words[i]) exp_q.push_back({m_words[i], (i == m_words.size() - 1), m_dest});
      m_busy = 1'b1;
    end
    if (v[0]) check("tvalid_after_start", {31'd0, tx_tvalid}, {31'd0, m_busy});
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx_tvalid) && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("packet_completes_in_budget", {31'd0, (n < 600)}, 32'd1);
    if (m_busy) begin
      m_busy = 1'b0;
      m_words.delete();
      m_irq = 1'b1;
      m_pkt = (m_pkt + 1) % 256;
    end
    exp_q.delete();
  endtask

  task automatic check_regs(input string tag);
    logic [7:0] d;
    avl_rd(8'h00, d); check({tag, "_status"},  {24'd0, d}, {24'd0, model_status()});
    avl_rd(8'h04, d); check({tag, "_count"},   {24'd0, d}, m_words.size());
    avl_rd(8'h05, d); check({tag, "_pkt_cnt"}, {24'd0, d}, m_pkt);
    avl_rd(8'h01, d); check({tag, "_dest"},    {24'd0, d}, {30'd0, m_dest});
    check({tag, "_irq_pin"}, {31'd0, irq}, {31'd0, m_irq});
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_words.delete();
    m_err = 1'b0; m_irq = 1'b0; m_busy = 1'b0; m_pkt = 0; m_dest = 2'd0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int vc0;
    int len;
    logic [7:0] rd;

    reset = 1'b1; writedata = '0; write = 1'b0; chipselect = 1'b0; address = '0; read = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_tvalid", {31'd0, tx_tvalid}, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_readdata", {24'd0, readdata}, 32'd0);
    reset = 1'b0;
    avl_rd(8'h07, rd); check("unmapped_read", {24'd0, rd}, 32'd0);
    check_regs("reset");

    // Basic 3-word packet at full throughput
    ready_mode = 0;
    push_word(16'hA1B2); push_word(16'hC3D4); push_word(16'hE5F6);
    set_dest(2'd2);
    vc0 = valid_cycles;
    ctrl(8'h01);
    wait_done();
    check("three_beats_back_to_back", valid_cycles - vc0, 32'd3);
    check_regs("pkt1");

    // Same packet under a fixed stall pattern
    ctrl(8'h04);
    pat_idx = 0; ready_mode = 1;
    push_word(16'hA1B2); push_word(16'hC3D4); push_word(16'hE5F6);
    ctrl(8'h01);
    wait_done();
    check_regs("stall");

    // Overfill: 17 random words into a 16-deep buffer
    ready_mode = 2;
    ctrl(8'h04);
    for (int i = 0; i < DEPTH + 1; i++) push_word(16'($urandom));
    set_dest(2'($urandom_range(0, 3)));
    check_regs("full");
    ctrl(8'h01);
    wait_done();
    check_regs("after_full");
    ctrl(8'h06);

    // START with nothing loaded, and START+CLEAR together
    ctrl(8'h01);
    repeat (3) @(negedge clk);
    check("empty_start_no_tvalid", {31'd0, tx_tvalid}, 32'd0);
    push_word(16'h1234);
    ctrl(8'h03);
    repeat (2) @(negedge clk);
    check("start_with_clear_no_tvalid", {31'd0, tx_tvalid}, 32'd0);
    check_regs("start_clear");

    // Random packets, random length/dest/backpressure
    for (int p = 0; p < 4; p++) begin
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) push_word(16'($urandom));
      set_dest(2'($urandom_range(0, 3)));
      ctrl(8'h01);
      wait_done();
      ctrl(8'h04);
    end
    check_regs("random");

    // Writes during SEND with the sink stalled
    ready_mode = 3;
    for (int i = 0; i < 4; i++) push_word(16'h5000 + 16'(i));
    set_dest(2'd1);
    ctrl(8'h01);
    ctrl(8'h01);
    push_word(16'hDEAD);
    set_dest(2'd3);
    check("tdest_latched", {30'd0, tx_tdest}, 32'd1);
    check_regs("during_send");
    ctrl(8'h02);
    check_regs("clear_in_send");
    ready_mode = 2;
    wait_done();
    check_regs("after_send_writes");

    // Reset in the middle of a 5-word packet
    ctrl(8'h06);
    ready_mode = 0;
    for (int i = 0; i < 5; i++) push_word(16'($urandom));
    vc0 = hs_count;
    ctrl(8'h01);
    for (int i = 0; i < 200 && hs_count < vc0 + 2; i++) @(posedge clk);
    check("two_beats_before_reset", {31'd0, (hs_count >= vc0 + 2)}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("reset_drops_tvalid", {31'd0, tx_tvalid}, 32'd0);
    check("reset_tdata_zero", {16'd0, tx_tdata}, 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_regs("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
